// File: rtl/qed_dup_fifo.sv
// QED duplicate-instruction queue: serves original fetches and queues their register-remapped
// duplicates. Define QED_ISSUE_CNT_EN to enable the issue counters.
module qed_dup_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [31:0]                instruction_in,
    input  logic                       exec_dup,
    input  logic                       inst_ren,
    input  logic [63:0]                inst_raddr,
    output logic [31:0]                instruction_out,
    output logic                       vld_out,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [15:0]                num_orig_issued,
    output logic [15:0]                num_dup_issued
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Remap every used, nonzero register field into the upper register bank.
    function automatic logic [31:0] dup(input logic [31:0] w);
        logic [31:0] r;
        logic        use_rd;
        logic        use_rs1;
        logic        use_rs2;
        r       = w;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (w[6:0])
            7'b0110011, 7'b0111011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0110111, 7'b0010111, 7'b1101111: begin
                use_rd = 1'b1;
            end
            default: ;
        endcase
        if (use_rd  && (w[11:7]  != 5'd0)) r[11] = 1'b1;
        if (use_rs1 && (w[19:15] != 5'd0)) r[19] = 1'b1;
        if (use_rs2 && (w[24:20] != 5'd0)) r[24] = 1'b1;
        return r;
    endfunction

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic [31:0]   out_q, out_d;
    logic          vld_q, vld_d;
    logic [63:0]   last_addr_q, last_addr_d;
    logic          last_vld_q, last_vld_d;

    logic fetch;
    logic refetch;
    logic new_fetch;
    logic push;
    logic pop;

    always_comb begin
        fetch     = ena & inst_ren;
        refetch   = fetch & last_vld_q & (inst_raddr == last_addr_q);
        new_fetch = fetch & ~refetch;
        push      = new_fetch & ~exec_dup & ~full_q;
        pop       = new_fetch & exec_dup & ~empty_q;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_d       = out_q;
        vld_d       = fetch;
        last_addr_d = last_addr_q;
        last_vld_d  = last_vld_q;

        if (new_fetch) begin
            last_addr_d = inst_raddr;
            last_vld_d  = 1'b1;
            out_d       = NOP;
        end
        if (push) begin
            out_d    = instruction_in;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + CW'(1);
        end
        if (pop) begin
            out_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q - CW'(1);
        end
        // A refetch replays the held word; out_d already defaults to it.

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == CW'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            out_q       <= NOP;
            vld_q       <= 1'b0;
            last_addr_q <= '0;
            last_vld_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            out_q       <= out_d;
            vld_q       <= vld_d;
            last_addr_q <= last_addr_d;
            last_vld_q  <= last_vld_d;
        end
    end

    // Storage needs no reset; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= dup(instruction_in);
        end
    end

`ifdef QED_ISSUE_CNT_EN
    logic [15:0] orig_cnt_q;
    logic [15:0] dup_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            orig_cnt_q <= '0;
            dup_cnt_q  <= '0;
        end else begin
            if (push) orig_cnt_q <= orig_cnt_q + 16'd1;
            if (pop)  dup_cnt_q  <= dup_cnt_q + 16'd1;
        end
    end

    assign num_orig_issued = orig_cnt_q;
    assign num_dup_issued  = dup_cnt_q;
`else
    assign num_orig_issued = 16'd0;
    assign num_dup_issued  = 16'd0;
`endif

    assign instruction_out = out_q;
    assign vld_out         = vld_q;
    assign fifo_full       = full_q;
    assign fifo_empty      = empty_q;
    assign fifo_count      = count_q;

endmodule

// File: tb/tb_qed_dup_fifo.sv
// Self-checking bench for qed_dup_fifo: queue-based reference model checked every cycle,
// plus directed literal expectations.
module tb_qed_dup_fifo;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [31:0] instruction_in;
    logic        exec_dup;
    logic        inst_ren;
    logic [63:0] inst_raddr;
    logic [31:0] instruction_out;
    logic        vld_out;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  fifo_count;
    logic [15:0] num_orig_issued;
    logic [15:0] num_dup_issued;

    int n_checks = 0;
    int n_errors = 0;

    qed_dup_fifo #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .ena             (ena),
        .instruction_in  (instruction_in),
        .exec_dup        (exec_dup),
        .inst_ren        (inst_ren),
        .inst_raddr      (inst_raddr),
        .instruction_out (instruction_out),
        .vld_out         (vld_out),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .fifo_count      (fifo_count),
        .num_orig_issued (num_orig_issued),
        .num_dup_issued  (num_dup_issued)
    );

    always #5 clk = ~clk;

    // Reference model: field-wise register renaming, xN -> xN+16.
    function automatic logic [31:0] model_dup(input logic [31:0] w);
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        bit u_rd;
        bit u_rs1;
        bit u_rs2;
        rd  = w[11:7];
        rs1 = w[19:15];
        rs2 = w[24:20];
        u_rd  = w[6:0] inside {7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0000011,
                               7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111};
        u_rs1 = w[6:0] inside {7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0000011,
                               7'b1100111, 7'b0100011, 7'b1100011};
        u_rs2 = w[6:0] inside {7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011};
        if (u_rd  && rd  != 0) rd  = rd  + 5'd16;
        if (u_rs1 && rs1 != 0) rs1 = rs1 + 5'd16;
        if (u_rs2 && rs2 != 0) rs2 = rs2 + 5'd16;
        return {w[31:25], rs2, rs1, w[14:12], rd, w[6:0]};
    endfunction

    logic [31:0] mq[$];
    logic [31:0] m_out;
    bit          m_vld;
    logic [63:0] m_last;
    bit          m_last_vld;
    int          m_orig;
    int          m_dupc;
    bit          m_init = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_out      = NOP;
            m_vld      = 0;
            m_last_vld = 0;
            m_orig     = 0;
            m_dupc     = 0;
            m_init     = 1;
        end else if (m_init) begin
            m_vld = ena && inst_ren;
            if (ena && inst_ren) begin
                if (m_last_vld && inst_raddr == m_last) begin
                    // replay: nothing changes
                end else begin
                    m_last     = inst_raddr;
                    m_last_vld = 1;
                    if (!exec_dup) begin
                        if (mq.size() < DEPTH) begin
                            m_out = instruction_in;
                            mq.push_back(model_dup(instruction_in));
                            m_orig = (m_orig + 1) % 65536;
                        end else begin
                            m_out = NOP;
                        end
                    end else begin
                        if (mq.size() > 0) begin
                            m_out = mq.pop_front();
                            m_dupc = (m_dupc + 1) % 65536;
                        end else begin
                            m_out = NOP;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            chk("cyc_vld", 32'(vld_out), 32'(m_vld));
            chk("cyc_out", instruction_out, m_out);
            chk("cyc_count", 32'(fifo_count), 32'(mq.size()));
            chk("cyc_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
            chk("cyc_empty", 32'(fifo_empty), 32'(mq.size() == 0));
`ifdef QED_ISSUE_CNT_EN
            chk("cyc_norig", 32'(num_orig_issued), 32'(m_orig));
            chk("cyc_ndup", 32'(num_dup_issued), 32'(m_dupc));
`else
            chk("cyc_norig", 32'(num_orig_issued), 32'd0);
            chk("cyc_ndup", 32'(num_dup_issued), 32'd0);
`endif
        end
    end

    task automatic drive(input bit r, input bit en, input bit ren, input bit d,
                         input logic [63:0] a, input logic [31:0] ins);
        @(negedge clk);
        rst            = r;
        ena            = en;
        inst_ren       = ren;
        exec_dup       = d;
        inst_raddr     = a;
        instruction_in = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic orig(input logic [63:0] a, input logic [31:0] ins);
        drive(0, 1, 1, 0, a, ins);
    endtask

    task automatic dupf(input logic [63:0] a);
        drive(0, 1, 1, 1, a, 32'hDEAD_BEEF);
    endtask

    task automatic idle();
        drive(0, 1, 0, 0, 64'h0, 32'h0);
    endtask

    logic [31:0] fill_vec [8];

    initial begin
        fill_vec[0] = 32'h0020_A023; // sw x2,0(x1)
        fill_vec[1] = 32'h0001_22B7; // lui x5
        fill_vec[2] = 32'h0000_000F; // fence: untouched
        fill_vec[3] = 32'h0031_0463; // beq x2,x3
        fill_vec[4] = 32'h0040_8067; // jalr x0,4(x1)
        fill_vec[5] = 32'h4020_83BB; // subw x7,x1,x2
        fill_vec[6] = 32'h0000_0517; // auipc x10
        fill_vec[7] = 32'h00C0_006F; // jal x0

        rst = 1; ena = 0; inst_ren = 0; exec_dup = 0; inst_raddr = '0; instruction_in = '0;
        drive(1, 0, 0, 0, 64'h0, 32'h0);
        drive(1, 1, 1, 0, 64'h0, 32'h1111_1111);
        chk("rst_vld", 32'(vld_out), 32'd0);
        chk("rst_out", instruction_out, NOP);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);

        orig(64'h0, 32'h0020_81B3);
        chk("orig_out", instruction_out, 32'h0020_81B3);
        chk("orig_count", 32'(fifo_count), 32'd1);
        dupf(64'h4);
        chk("dup_out", instruction_out, 32'h0128_89B3);
        chk("dup_count", 32'(fifo_count), 32'd0);

        orig(64'h8, 32'h0070_0293);
        dupf(64'hC);
        chk("x0_keep", instruction_out, 32'h0070_0A93);

        drive(0, 0, 1, 0, 64'h20, 32'h0020_81B3);
        chk("ena0_vld", 32'(vld_out), 32'd0);
        chk("ena0_hold", instruction_out, 32'h0070_0A93);

        for (int i = 0; i < 8; i++) orig(64'h100 + 64'(4 * i), fill_vec[i]);
        chk("full_flag", 32'(fifo_full), 32'd1);
        orig(64'h200, 32'h0020_81B3);
        chk("full_nop", instruction_out, NOP);
        chk("full_vld", 32'(vld_out), 32'd1);
        chk("full_count", 32'(fifo_count), 32'd8);
        dupf(64'h300);
        chk("store_dup", instruction_out, 32'h0128_A023);
        dupf(64'h304);
        chk("lui_dup", instruction_out, 32'h0001_2AB7);
        for (int i = 2; i < 8; i++) dupf(64'h300 + 64'(4 * i));
        chk("drained", 32'(fifo_empty), 32'd1);

        orig(64'h10, 32'h0011_0113);
        chk("refetch_a", instruction_out, 32'h0011_0113);
        orig(64'h10, 32'h0011_0113);
        chk("refetch_b", instruction_out, 32'h0011_0113);
        chk("refetch_cnt", 32'(fifo_count), 32'd1);
        dupf(64'h14);
        chk("refetch_dup", instruction_out, 32'h0019_0913);
        dupf(64'h18);
        chk("empty_nop", instruction_out, NOP);
        idle();
        chk("idle_vld", 32'(vld_out), 32'd0);
        dupf(64'h18);
        chk("replay_vld", 32'(vld_out), 32'd1);

        orig(64'h40, 32'h0020_81B3);
        orig(64'h44, 32'h0070_0293);
        orig(64'h48, 32'h0011_0113);
        drive(1, 1, 1, 0, 64'h4C, 32'h0020_81B3);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_norig", 32'(num_orig_issued), 32'd0);
        dupf(64'h50);
        chk("mid_rst_nop", instruction_out, NOP);
        chk("mid_rst_ndup", 32'(num_dup_issued), 32'd0);

        idle();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
